mem_stage: RTL and testbench

- Pipeline stage directly downstream of execute; registers the IX→MEM bundle and performs the data-memory load/store over a req/gnt/rvalid handshake.
- Produces the registered MEM→WB bundle: dest_reg_index/value/write_valid_memwb_p1, which feeds the register-file write port in execute.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_timeout_ctr.sv | 32 +++
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory stage: FSM states, the IX->MEM and MEM->WB bundles,
// store-type bit positions and the alignment helper.
package mem_pkg;

    localparam int MEM_DW    = 16;
    localparam int REG_IDX_W = 3;
    localparam int STORE_BIT = 0;
    localparam int STU_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [MEM_DW-1:0]    value;
        logic [REG_IDX_W-1:0] index;
        logic                 wr_valid;
        logic [MEM_DW-1:0]    addr;
        logic                 ldst_valid;
        logic [1:0]           store_valid;
        logic [MEM_DW-1:0]    wdata;
    } ixmem_bus_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] index;
        logic [MEM_DW-1:0]    value;
        logic                 valid;
    } memwb_bus_t;

    // Halfword accesses must sit on an even byte address.
    function automatic logic addr_misaligned(input logic [MEM_DW-1:0] addr);
        return (addr & {{(MEM_DW-1){1'b0}}, 1'b1}) != {MEM_DW{1'b0}};
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts cycles spent in REQ/RESP and flags the last allowed cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter; saturates on the final cycle so it can never wrap while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LAST_CNT)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST_CNT);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the IX->MEM bundle, runs the dmem req/gnt/rvalid
// handshake and produces the registered MEM->WB bundle. Optional MEM_ALIGN_CHECK_EN
// aborts odd-address accesses with mem_err_p1 instead of issuing them.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dest_reg_value_ixmem_p1,
    input  logic [2:0]        dest_reg_index_ixmem_p1,
    input  logic              dest_reg_write_valid_ixmem_p1,
    input  logic [DATA_W-1:0] mem_addr_ixmem_p1,
    input  logic              ldst_valid_ixmem_p1,
    input  logic [1:0]        store_valid_ixmem_p1,
    input  logic [DATA_W-1:0] mem_data_in_ixmem_p1,
    output logic              stall_mem_p1,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [2:0]        dest_reg_index_memwb_p1,
    output logic [DATA_W-1:0] dest_reg_value_memwb_p1,
    output logic              dest_reg_write_valid_memwb_p1,
    output logic              mem_err_p1
);

    mem_state_t  state_r;
    mem_state_t  next_state_s;
    ixmem_bus_t  ix_s;
    ixmem_bus_t  pipe_r;
    logic        pipe_valid_r;
    memwb_bus_t  wb_r;
    memwb_bus_t  wb_next_s;
    logic        err_r;
    logic        err_next_s;
    logic        stall_s;
    logic        capture_s;
    logic        go_req_s;
    logic        misalign_abort_s;
    logic        expired_s;
    logic        busy_s;
    logic        is_store_s;
    logic        is_stu_s;
    logic              dmem_req_r;
    logic              dmem_we_r;
    logic [DATA_W-1:0] dmem_addr_r;
    logic [DATA_W-1:0] dmem_wdata_r;

    // Gather the incoming IX bundle into the shared struct.
    always_comb begin
        ix_s.value       = dest_reg_value_ixmem_p1;
        ix_s.index       = dest_reg_index_ixmem_p1;
        ix_s.wr_valid    = dest_reg_write_valid_ixmem_p1;
        ix_s.addr        = mem_addr_ixmem_p1;
        ix_s.ldst_valid  = ldst_valid_ixmem_p1;
        ix_s.store_valid = store_valid_ixmem_p1;
        ix_s.wdata       = mem_data_in_ixmem_p1;
    end

    assign is_store_s = pipe_r.store_valid[STORE_BIT] | pipe_r.store_valid[STU_BIT];
    assign is_stu_s   = pipe_r.store_valid[STU_BIT];
    assign busy_s     = (state_r == REQ) || (state_r == RESP);

`ifdef MEM_ALIGN_CHECK_EN
    assign go_req_s         = ix_s.ldst_valid & ~addr_misaligned(ix_s.addr);
    assign misalign_abort_s = pipe_valid_r & pipe_r.ldst_valid & addr_misaligned(pipe_r.addr);
`else
    assign go_req_s         = ix_s.ldst_valid;
    assign misalign_abort_s = 1'b0;
`endif

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (capture_s & go_req_s),
        .enable  (busy_s),
        .expired (expired_s)
    );

    // Stall and next-state: a finishing or aborted access releases the stall so the
    // next IX op is captured on the same edge.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = 1'b0;
            end
            REQ: begin
                if (dmem_gnt && is_store_s) begin
                    stall_s = 1'b0;
                end else if (expired_s) begin
                    stall_s = 1'b0;
                end else begin
                    stall_s = 1'b1;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    stall_s = 1'b0;
                end else if (expired_s) begin
                    stall_s = 1'b0;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase

        capture_s = ~stall_s;
        if (capture_s) begin
            next_state_s = go_req_s ? REQ : IDLE;
        end else if ((state_r == REQ) && dmem_gnt) begin
            next_state_s = RESP;
        end else begin
            next_state_s = state_r;
        end
    end

    // Writeback and error pulse selection for the edge that ends the current op.
    always_comb begin
        wb_next_s       = wb_r;
        wb_next_s.valid = 1'b0;
        err_next_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pipe_valid_r && !pipe_r.ldst_valid) begin
                    wb_next_s.index = pipe_r.index;
                    wb_next_s.value = pipe_r.value;
                    wb_next_s.valid = pipe_r.wr_valid;
                end else begin
                    err_next_s = misalign_abort_s;
                end
            end
            REQ: begin
                if (dmem_gnt && is_store_s) begin
                    wb_next_s.index = pipe_r.index;
                    wb_next_s.value = pipe_r.addr;
                    wb_next_s.valid = is_stu_s;
                end else begin
                    err_next_s = expired_s;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    wb_next_s.index = pipe_r.index;
                    wb_next_s.value = dmem_rdata;
                    wb_next_s.valid = 1'b1;
                end else begin
                    err_next_s = expired_s;
                end
            end
            default: begin
                err_next_s = 1'b0;
            end
        endcase
    end

    // FSM state, pipe register and registered writeback/error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            pipe_r       <= {$bits(ixmem_bus_t){1'b0}};
            pipe_valid_r <= 1'b0;
            wb_r         <= {$bits(memwb_bus_t){1'b0}};
            err_r        <= 1'b0;
        end else begin
            state_r <= next_state_s;
            wb_r    <= wb_next_s;
            err_r   <= err_next_s;
            if (capture_s) begin
                pipe_r       <= ix_s;
                pipe_valid_r <= ix_s.ldst_valid | ix_s.wr_valid;
            end else begin
                pipe_r       <= pipe_r;
                pipe_valid_r <= pipe_valid_r;
            end
        end
    end

    // Request outputs are loaded on entry to REQ and held until the grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {DATA_W{1'b0}};
            dmem_wdata_r <= {DATA_W{1'b0}};
        end else if (next_state_s == REQ) begin
            dmem_req_r <= 1'b1;
            if (capture_s) begin
                dmem_we_r    <= |ix_s.store_valid;
                dmem_addr_r  <= ix_s.addr;
                dmem_wdata_r <= ix_s.wdata;
            end else begin
                dmem_we_r    <= is_store_s;
                dmem_addr_r  <= pipe_r.addr;
                dmem_wdata_r <= pipe_r.wdata;
            end
        end else begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {DATA_W{1'b0}};
            dmem_wdata_r <= {DATA_W{1'b0}};
        end
    end

    assign stall_mem_p1                  = stall_s;
    assign dmem_req                      = dmem_req_r;
    assign dmem_we                       = dmem_we_r;
    assign dmem_addr                     = dmem_addr_r;
    assign dmem_wdata                    = dmem_wdata_r;
    assign dest_reg_index_memwb_p1       = wb_r.index;
    assign dest_reg_value_memwb_p1       = wb_r.value;
    assign dest_reg_write_valid_memwb_p1 = wb_r.valid;
    assign mem_err_p1                    = err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a per-cycle timeline model built from op-level
// latency arithmetic, a negedge compare process, and hand-computed literal checks.
module tb_mem_stage;

    localparam int T_CYC = 255;
    localparam int MAXC  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [2:0]  index_in = 3'd0;
    logic        wr_in = 1'b0;
    logic [15:0] addr_in = 16'h0;
    logic        ldst_in = 1'b0;
    logic [1:0]  st_in = 2'b00;
    logic [15:0] wdata_in = 16'h0;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [15:0] dmem_rdata = 16'h0;
    logic        stall, dmem_req, dmem_we, wbv, mem_err;
    logic [15:0] dmem_addr, dmem_wdata, wb_val;
    logic [2:0]  wb_idx;

    mem_stage #(.TIMEOUT_CYC(T_CYC), .DATA_W(16)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .dest_reg_value_ixmem_p1       (value_in),
        .dest_reg_index_ixmem_p1       (index_in),
        .dest_reg_write_valid_ixmem_p1 (wr_in),
        .mem_addr_ixmem_p1             (addr_in),
        .ldst_valid_ixmem_p1           (ldst_in),
        .store_valid_ixmem_p1          (st_in),
        .mem_data_in_ixmem_p1          (wdata_in),
        .stall_mem_p1                  (stall),
        .dmem_req                      (dmem_req),
        .dmem_we                       (dmem_we),
        .dmem_addr                     (dmem_addr),
        .dmem_wdata                    (dmem_wdata),
        .dmem_gnt                      (dmem_gnt),
        .dmem_rvalid                   (dmem_rvalid),
        .dmem_rdata                    (dmem_rdata),
        .dest_reg_index_memwb_p1       (wb_idx),
        .dest_reg_value_memwb_p1       (wb_val),
        .dest_reg_write_valid_memwb_p1 (wbv),
        .mem_err_p1                    (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected timeline, indexed by absolute cycle number.
    bit          e_stall[MAXC];
    bit          e_req[MAXC];
    bit          e_err[MAXC];
    bit          e_wbv[MAXC];
    bit          e_we[MAXC];
    logic [2:0]  e_wbi[MAXC];
    logic [15:0] e_wbval[MAXC];
    logic [15:0] e_addr[MAXC];
    logic [15:0] e_wdata[MAXC];

    int          stall_cnt = 0;
    int          err_cnt = 0;
    int          wb_cnt = 0;
    logic [15:0] last_wb_val = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Compare DUT outputs against the model timeline mid-cycle.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("stall", {31'd0, stall}, {31'd0, e_stall[cyc]});
            check("dmem_req", {31'd0, dmem_req}, {31'd0, e_req[cyc]});
            check("mem_err", {31'd0, mem_err}, {31'd0, e_err[cyc]});
            check("wb_valid", {31'd0, wbv}, {31'd0, e_wbv[cyc]});
            if (e_wbv[cyc]) begin
                check("wb_index", {29'd0, wb_idx}, {29'd0, e_wbi[cyc]});
                check("wb_value", {16'd0, wb_val}, {16'd0, e_wbval[cyc]});
            end
            if (e_req[cyc]) begin
                check("dmem_addr", {16'd0, dmem_addr}, {16'd0, e_addr[cyc]});
                check("dmem_we", {31'd0, dmem_we}, {31'd0, e_we[cyc]});
                check("dmem_wdata", {16'd0, dmem_wdata}, {16'd0, e_wdata[cyc]});
            end
            if (stall) stall_cnt++;
            if (mem_err) err_cnt++;
            if (wbv) begin
                wb_cnt++;
                last_wb_val = wb_val;
            end
        end
    end

    task automatic bubble();
        value_in = 16'h0; index_in = 3'd0; wr_in = 1'b0; addr_in = 16'h0;
        ldst_in = 1'b0; st_in = 2'b00; wdata_in = 16'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 16'h0;
        end
    endtask

    task automatic set_req(input int c, input logic [15:0] a, input logic we, input logic [15:0] d);
        e_req[c] = 1'b1; e_addr[c] = a; e_we[c] = we; e_wdata[c] = d;
    endtask

    task automatic set_wb(input int c, input logic [2:0] i, input logic [15:0] v);
        e_wbv[c] = 1'b1; e_wbi[c] = i; e_wbval[c] = v;
    endtask

    // Present one op, let it be captured, record its expected timeline and play the
    // memory side (g = grant on the g-th request cycle, 0 = never; r = rvalid delay).
    // Returns during the op's last busy cycle so the next op can follow with no bubble.
    task automatic run_op(input logic [15:0] val, input logic [2:0] idx, input logic wr,
                          input logic [15:0] addr, input logic ldst, input logic [1:0] st,
                          input logic [15:0] wd, input int g, input int r, input logic [15:0] rd);
        int c, busy, gnt_c, rv_c;
        bit mis;
        value_in = val; index_in = idx; wr_in = wr; addr_in = addr;
        ldst_in = ldst; st_in = st; wdata_in = wd;
        @(posedge clk); #1;
        c = cyc;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 16'h0;
        bubble();
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ldst & addr[0];
`endif
        gnt_c = -1;
        rv_c  = -1;
        if (!ldst) begin
            busy = 1;
            if (wr) set_wb(c + 1, idx, val);
        end else if (mis) begin
            busy = 1;
            e_err[c + 1] = 1'b1;
        end else if (g == 0) begin
            busy = T_CYC;
            for (int k = 0; k < T_CYC; k++) set_req(c + k, addr, |st, wd);
            for (int k = 0; k < T_CYC - 1; k++) e_stall[c + k] = 1'b1;
            e_err[c + T_CYC] = 1'b1;
        end else if (st != 2'b00) begin
            busy  = g;
            gnt_c = c + g - 1;
            for (int k = 0; k < g; k++) set_req(c + k, addr, 1'b1, wd);
            for (int k = 0; k < g - 1; k++) e_stall[c + k] = 1'b1;
            if (st[1]) set_wb(c + g, idx, addr);
        end else begin
            busy  = g + r;
            gnt_c = c + g - 1;
            rv_c  = c + g + r - 1;
            for (int k = 0; k < g; k++) set_req(c + k, addr, 1'b0, wd);
            for (int k = 0; k < g + r - 1; k++) e_stall[c + k] = 1'b1;
            set_wb(c + g + r, idx, rd);
        end
        for (int k = 0; k < busy; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            dmem_gnt    = (cyc == gnt_c);
            dmem_rvalid = (cyc == rv_c);
            dmem_rdata  = (cyc == rv_c) ? rd : 16'h0;
        end
    endtask

    int s0, e0, w0;

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_req", {31'd0, dmem_req}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_wbv", {31'd0, wbv}, 32'd0);
        check("reset_err", {31'd0, mem_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        idle(1);

        // ALU op: writeback one cycle after capture, never stalls
        s0 = stall_cnt; w0 = wb_cnt;
        run_op(16'h1234, 3'd3, 1'b1, 16'h0, 1'b0, 2'b00, 16'h0, 0, 0, 16'h0);
        idle(2);
        check("alu_stall_cycles", stall_cnt - s0, 32'd0);
        check("alu_wb_count", wb_cnt - w0, 32'd1);
        check("alu_wb_value", {16'd0, last_wb_val}, 32'h1234);

        // Load: grant on 3rd request cycle, rvalid 3 cycles after grant
        s0 = stall_cnt;
        run_op(16'h0, 3'd2, 1'b0, 16'h0040, 1'b1, 2'b00, 16'h0, 3, 3, 16'hBEEF);
        idle(2);
        check("load_stall_cycles", stall_cnt - s0, 32'd5);
        check("load_wb_value", {16'd0, last_wb_val}, 32'hBEEF);

        // Store-with-update, immediate grant
        s0 = stall_cnt;
        run_op(16'h0, 3'd4, 1'b0, 16'h0100, 1'b1, 2'b10, 16'h00AA, 1, 0, 16'h0);
        idle(2);
        check("stu_stall_cycles", stall_cnt - s0, 32'd0);
        check("stu_wb_value", {16'd0, last_wb_val}, 32'h0100);

        // Plain store then ALU op back-to-back
        w0 = wb_cnt;
        run_op(16'h0, 3'd1, 1'b0, 16'h0080, 1'b1, 2'b01, 16'h7777, 1, 0, 16'h0);
        run_op(16'h5555, 3'd5, 1'b1, 16'h0, 1'b0, 2'b00, 16'h0, 0, 0, 16'h0);
        idle(2);
        check("st_alu_wb_count", wb_cnt - w0, 32'd1);
        check("st_alu_wb_value", {16'd0, last_wb_val}, 32'h5555);

        // Odd address load
        e0 = err_cnt; s0 = stall_cnt;
        run_op(16'h0, 3'd6, 1'b0, 16'h0041, 1'b1, 2'b00, 16'h0, 1, 1, 16'h1111);
        idle(2);
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign_err_count", err_cnt - e0, 32'd1);
        check("misalign_stall_cycles", stall_cnt - s0, 32'd0);
`else
        check("odd_addr_err_count", err_cnt - e0, 32'd0);
        check("odd_addr_wb_value", {16'd0, last_wb_val}, 32'h1111);
`endif

        // Load that is never granted
        e0 = err_cnt; s0 = stall_cnt; w0 = wb_cnt;
        run_op(16'h0, 3'd7, 1'b0, 16'h0200, 1'b1, 2'b00, 16'h0, 0, 0, 16'h0);
        run_op(16'h0ABC, 3'd1, 1'b1, 16'h0, 1'b0, 2'b00, 16'h0, 0, 0, 16'h0);
        idle(2);
        check("timeout_err_count", err_cnt - e0, 32'd1);
        check("timeout_stall_cycles", stall_cnt - s0, 32'd254);
        check("timeout_wb_count", wb_cnt - w0, 32'd1);
        check("after_timeout_wb", {16'd0, last_wb_val}, 32'h0ABC);
        chk_en = 1'b0;

        // Reset asserted while a load waits for rvalid
        value_in = 16'h0; index_in = 3'd1; addr_in = 16'h0300; ldst_in = 1'b1;
        @(posedge clk); #1;
        bubble();
        dmem_gnt = 1'b1;
        check("rq_req_high", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("resp_stall_high", {31'd0, stall}, 32'd1);
        check("resp_req_low", {31'd0, dmem_req}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_resp_req", {31'd0, dmem_req}, 32'd0);
        check("rst_resp_stall", {31'd0, stall}, 32'd0);
        check("rst_resp_wbv", {31'd0, wbv}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset asserted while a request is outstanding
        addr_in = 16'h0302; ldst_in = 1'b1;
        @(posedge clk); #1;
        bubble();
        check("req2_req_high", {31'd0, dmem_req}, 32'd1);
        check("req2_stall_high", {31'd0, stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_req_req", {31'd0, dmem_req}, 32'd0);
        check("rst_req_stall", {31'd0, stall}, 32'd0);
        check("rst_req_err", {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
